div_share_ctrl: RTL and testbench

- Round-robin controller that shares one 32-bit sequential divider (start/done handshake, quotient output) among N_REQ requesters.
- Accepts one request at a time and registers its operands.
- Holds `div_dividend_o` / `div_divisor_o` stable for the whole divide, pulses `div_start_o`, then returns the quotient to the granted requester.
- Sits between the measurement/scaling logic of the frequency counter and the shared divider instance.

---
 rtl/div_share_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/div_share_ctrl.sv | 115 +++++++++++
 tb/tb_div_share_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_pkg.sv
// Shared types for the divider-sharing controller: FSM states and response error codes.
package div_share_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_OK      = 2'b00;
  localparam err_t ERR_DIV0    = 2'b01;
  localparam err_t ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  input  logic                     en_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic            found;
  logic [IdxW-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = IdxW'((32'(ptr_i) + i) % N_REQ);
      if (en_i && !found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one sequential divider among N_REQ requesters, one transaction at a time,
// with divide-by-zero bypass and a start-to-done timeout.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*W-1:0] dividend_i,
  input  logic [N_REQ*W-1:0] divisor_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   resp_valid_o,
  output logic [W-1:0]       quotient_o,
  output logic [1:0]         err_o,
  output logic               busy_o,
  output logic               div_start_o,
  output logic [W-1:0]       div_dividend_o,
  output logic [W-1:0]       div_divisor_o,
  input  logic [W-1:0]       div_quotient_i,
  input  logic               div_done_i
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  state_t          state_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] owner_q;
  logic [W-1:0]    dividend_q;
  logic [W-1:0]    divisor_q;
  logic [W-1:0]    quotient_q;
  err_t            err_q;
  logic [CntW-1:0] cnt_q;

  logic            arb_en;
  logic [IdxW-1:0] arb_idx;

  // Gating with reset keeps gnt_o low while held in reset even if requests are up.
  assign arb_en = (state_q == IDLE) && reset_ni;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_i(req_i),
    .ptr_i(rr_ptr_q),
    .en_i (arb_en),
    .gnt_o(gnt_o),
    .idx_o(arb_idx)
  );

  assign resp_valid_o   = (state_q == RESP) ? (N_REQ'(1) << owner_q) : '0;
  assign div_start_o    = (state_q == ISSUE) && (divisor_q != '0);
  assign busy_o         = (state_q != IDLE);
  assign quotient_o     = quotient_q;
  assign err_o          = err_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quotient_q <= '0;
      err_q      <= ERR_OK;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|gnt_o) begin
            dividend_q <= dividend_i[arb_idx*W +: W];
            divisor_q  <= divisor_i[arb_idx*W +: W];
            owner_q    <= arb_idx;
            rr_ptr_q   <= (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + IdxW'(1);
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (divisor_q == '0) begin
            quotient_q <= '0;
            err_q      <= ERR_DIV0;
            state_q    <= RESP;
          end else begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (div_done_i) begin
            quotient_q <= div_quotient_i;
            err_q      <= ERR_OK;
            state_q    <= RESP;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            quotient_q <= '0;
            err_q      <= ERR_TIMEOUT;
            state_q    <= DRAIN;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESP: state_q <= IDLE;
        // Swallow the late done so it cannot be credited to the next owner.
        DRAIN: if (div_done_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Randomized scoreboard bench for div_share_ctrl with a behavioural divider and RR model.
module tb_div_share_ctrl;

  localparam int unsigned N  = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 64;

  logic           clk_i    = 1'b0;
  logic           reset_ni = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [N*W-1:0] dividend = '0;
  logic [N*W-1:0] divisor  = '0;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   resp_valid_o;
  logic [W-1:0]   quotient_o;
  logic [1:0]     err_o;
  logic           busy_o;
  logic           div_start_o;
  logic [W-1:0]   div_dividend_o;
  logic [W-1:0]   div_divisor_o;
  logic [W-1:0]   div_q    = '0;
  logic           div_done = 1'b0;

  div_share_ctrl #(
    .N_REQ  (N),
    .W      (W),
    .TIMEOUT(TO)
  ) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .req_i         (req),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .gnt_o         (gnt_o),
    .resp_valid_o  (resp_valid_o),
    .quotient_o    (quotient_o),
    .err_o         (err_o),
    .busy_o        (busy_o),
    .div_start_o   (div_start_o),
    .div_dividend_o(div_dividend_o),
    .div_divisor_o (div_divisor_o),
    .div_quotient_i(div_q),
    .div_done_i    (div_done)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         k;
    logic [W-1:0] q;
    logic [1:0] e;
    bit         div0;
    int         gcyc;
  } exp_t;

  exp_t         exp_q[$];
  int           nvec = 0, nfail = 0;
  int           cyc = 0, done_cyc = 0, last_gcyc = 0;
  int           nstart = 0, ngrant = 0, model_ptr = 0;
  bit           hang = 1'b0;
  logic [N-1:0] hold = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      int k = (ptr + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_divisor();
    case ($urandom_range(0, 7))
      0:       return '0;
      1, 2:    return W'($urandom_range(1, 15));
      default: return W'($urandom) >> $urandom_range(0, 24);
    endcase
  endfunction

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend[k*W +: W] = a;
    divisor[k*W +: W]  = b;
    req[k]             = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!(req == '0 && !busy_o && exp_q.size() == 0) && t < bound);
    nvec++;
    if (t >= bound) begin
      nfail++;
      $display("FAIL idle_wait: still busy after %0d cycles, required under %0d", t, bound);
    end
    @(posedge clk_i);
    #1;
  endtask

  // Requester agent + round-robin reference model; pushes expectations at grant.
  initial forever begin
    @(negedge clk_i);
    if (!reset_ni) begin
      model_ptr = 0;
      exp_q.delete();
    end else if (gnt_o != '0) begin : grant
      int k;
      exp_t e;
      logic [W-1:0] a, b;
      k = rr_pick(req, model_ptr);
      chk("gnt_onehot", 64'(gnt_o), (k < 0) ? 64'd0 : (64'd1 << k));
      chk("gnt_while_busy", 64'(busy_o), 64'd0);
      if (k >= 0) begin
        a = dividend[k*W +: W];
        b = divisor[k*W +: W];
        model_ptr = (k + 1) % N;
        last_gcyc = cyc;
        ngrant++;
        if (!hang) begin
          e.k    = k;
          e.q    = (b == 0) ? '0 : a / b;
          e.e    = (b == 0) ? 2'b01 : 2'b00;
          e.div0 = (b == 0);
          e.gcyc = cyc;
          exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        req[k]             = 1'b0;
        dividend[k*W +: W] = $urandom;
        divisor[k*W +: W]  = $urandom;
        if (hold[k]) set_req(k, W'($urandom) >> $urandom_range(0, 31), rand_divisor());
      end
    end else if (!busy_o && req != '0) begin
      chk("gnt_missing", 64'(gnt_o), 64'd1 << rr_pick(req, model_ptr));
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk_i);
    if (reset_ni && resp_valid_o != '0) begin : resp
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("stray_resp", 64'(resp_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_valid", 64'(resp_valid_o), 64'd1 << e.k);
        chk("quotient", 64'(quotient_o), 64'(e.q));
        chk("err", 64'(err_o), 64'(e.e));
        if (e.div0) chk("div0_latency", 64'(cyc - e.gcyc), 64'd2);
        else chk("done_latency", 64'(cyc - done_cyc), 64'd1);
      end
    end
  end

  // Behavioural divider: random latency, or never answers while hang is set.
  initial forever begin
    @(negedge clk_i);
    if (reset_ni && div_start_o) begin : divide
      logic [W-1:0] a, b;
      int lat;
      nstart++;
      a = div_dividend_o;
      b = div_divisor_o;
      chk("start_latency", 64'(cyc - last_gcyc), 64'd1);
      if (!hang) begin
        lat = $urandom_range(1, 12);
        repeat (lat) begin
          @(negedge clk_i);
          chk("divisor_stable", 64'(div_divisor_o), 64'(b));
          chk("dividend_stable", 64'(div_dividend_o), 64'(a));
          chk("start_pulse", 64'(div_start_o), 64'd0);
        end
        @(posedge clk_i);
        #1;
        div_q    = (b == 0) ? '1 : a / b;
        div_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk_i);
        #1;
        div_done = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t;
    logic [N-1:0] mask;

    // Reset with both requesters already asserting.
    #1 reset_ni = 1'b0;
    set_req(0, 100, 10);
    set_req(1, 81, 9);
    #2;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_start", 64'(div_start_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_quotient", 64'(quotient_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_divisor", 64'(div_divisor_o), 64'd0);
    hold = '1;
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;

    // Contention with both requests held: alternating grants.
    t = 0;
    while (ngrant < 8 && t < 400) begin
      @(posedge clk_i);
      t++;
    end
    chk("hold_grants", 64'(ngrant >= 8), 64'd1);
    hold = '0;
    wait_idle(200);

    n0 = nstart;
    set_req(0, 1000, 7);
    wait_idle(100);
    chk("single_start_count", 64'(nstart - n0), 64'd1);

    n0 = nstart;
    set_req(1, 55, 0);
    wait_idle(100);
    chk("div0_start_count", 64'(nstart - n0), 64'd0);

    // Spurious done while idle.
    div_q    = 32'hdead_beef;
    div_done = 1'b1;
    @(posedge clk_i);
    #1 div_done = 1'b0;
    @(negedge clk_i);
    chk("spurious_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 40; i++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++)
        if (mask[k]) set_req(k, W'($urandom) >> $urandom_range(0, 31), rand_divisor());
      wait_idle(200);
    end

    // Timeout: divider never answers until a late done.
    hang = 1'b1;
    n0   = nstart;
    set_req(0, $urandom, 5);
    t = 0;
    while (nstart == n0 && t < 50) begin
      @(posedge clk_i);
      t++;
    end
    chk("timeout_started", 64'(nstart - n0), 64'd1);
    repeat (98) @(posedge clk_i);
    @(negedge clk_i);
    chk("drain_busy", 64'(busy_o), 64'd1);
    @(posedge clk_i);
    #1 div_done = 1'b1;
    div_q = 32'h1234;
    @(posedge clk_i);
    #1 div_done = 1'b0;
    @(negedge clk_i);
    chk("drain_exit", 64'(busy_o), 64'd0);
    hang = 1'b0;
    @(posedge clk_i);
    #1 set_req(1, 777, 3);
    wait_idle(100);

    // Reset during WAIT aborts the transaction without a response.
    hang = 1'b1;
    n0   = nstart;
    set_req(0, 400, 4);
    t = 0;
    while (nstart == n0 && t < 50) begin
      @(posedge clk_i);
      t++;
    end
    repeat (5) @(posedge clk_i);
    #3 reset_ni = 1'b0;
    hang = 1'b0;
    set_req(1, 90, 9);
    set_req(0, 64, 8);
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_gnt", 64'(gnt_o), 64'd0);
    chk("midrst_resp", 64'(resp_valid_o), 64'd0);
    chk("midrst_start", 64'(div_start_o), 64'd0);
    chk("midrst_quotient", 64'(quotient_o), 64'd0);
    chk("midrst_divisor", 64'(div_divisor_o), 64'd0);
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    wait_idle(200);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
